// File: rtl/val2_shift_sequencer.sv
// Operand-2 shifter: decodes an immediate / shifted-register / memory-offset operand and
// shifts it one bit per cycle; done follows an accepted start by N+1 cycles. Define RRX_EN
// to treat a register ROR #0 as rotate-right-extended through the carry flag.
module val2_shift_sequencer #(
    parameter int REGISTER_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [REGISTER_LEN-1:0] Rm,
    input  logic [11:0]             shift_operand,
    input  logic                    immd,
    input  logic                    is_mem_command,
    input  logic                    carry_in,
    output logic                    busy,
    output logic                    done,
    output logic [REGISTER_LEN-1:0] val2_out,
    output logic                    shift_carry_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR, SH_RRX} shift_t;

    state_t                  state_q, state_d;
    shift_t                  type_q, type_d, ld_type;
    logic [REGISTER_LEN-1:0] work_q, work_d, ld_val, sh_val;
    logic [REGISTER_LEN-1:0] val2_q, val2_d;
    logic [5:0]              cnt_q, cnt_d, ld_cnt;
    logic                    carry_q, carry_d, sh_c;
    logic                    done_q, done_d;
    logic                    cout_q, cout_d;
    logic                    accept;

    // Operand decode for the request presented this cycle.
    always_comb begin
        ld_val  = Rm;
        ld_cnt  = 6'd0;
        ld_type = SH_LSL;
        if (is_mem_command) begin
            ld_val = {{(REGISTER_LEN-12){1'b0}}, shift_operand};
        end else if (immd) begin
            ld_val  = {{(REGISTER_LEN-8){1'b0}}, shift_operand[7:0]};
            ld_cnt  = {1'b0, shift_operand[11:8], 1'b0};
            ld_type = SH_ROR;
        end else if (!shift_operand[4]) begin
            ld_cnt = {1'b0, shift_operand[11:7]};
            case (shift_operand[6:5])
                2'b00:   ld_type = SH_LSL;
                2'b01:   ld_type = SH_LSR;
                2'b10:   ld_type = SH_ASR;
                default: ld_type = SH_ROR;
            endcase
            if (shift_operand[11:7] == 5'd0) begin
                if (ld_type == SH_LSR || ld_type == SH_ASR) begin
                    ld_cnt = 6'd32;
                end
`ifdef RRX_EN
                if (ld_type == SH_ROR) begin
                    ld_type = SH_RRX;
                    ld_cnt  = 6'd1;
                end
`endif
            end
        end
    end

    always_comb begin
        sh_val = work_q;
        sh_c   = carry_q;
        case (type_q)
            SH_LSL: begin sh_val = {work_q[REGISTER_LEN-2:0], 1'b0};        sh_c = work_q[REGISTER_LEN-1]; end
            SH_LSR: begin sh_val = {1'b0, work_q[REGISTER_LEN-1:1]};        sh_c = work_q[0]; end
            SH_ASR: begin sh_val = {work_q[REGISTER_LEN-1], work_q[REGISTER_LEN-1:1]}; sh_c = work_q[0]; end
            SH_ROR: begin sh_val = {work_q[0], work_q[REGISTER_LEN-1:1]};   sh_c = work_q[0]; end
            SH_RRX: begin sh_val = {carry_q, work_q[REGISTER_LEN-1:1]};     sh_c = work_q[0]; end
            default: begin sh_val = work_q; sh_c = carry_q; end
        endcase
    end

    assign accept = rst && start && (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        carry_d = carry_q;
        val2_d  = val2_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            SHIFT: begin
                work_d  = sh_val;
                carry_d = sh_c;
                cnt_d   = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    val2_d  = sh_val;
                    cout_d  = sh_c;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    work_d  = ld_val;
                    cnt_d   = ld_cnt;
                    type_d  = ld_type;
                    carry_d = carry_in;
                    if (ld_cnt == 6'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        val2_d  = ld_val;
                        cout_d  = carry_in;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= 6'd0;
            type_q  <= SH_LSL;
            carry_q <= 1'b0;
            val2_q  <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            carry_q <= carry_d;
            val2_q  <= val2_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    // busy stalls the pipeline from the accepting cycle onward, so it cannot wait for a flop.
    assign busy            = (state_q == SHIFT) || (accept && (ld_cnt != 6'd0));
    assign done            = done_q;
    assign val2_out        = val2_q;
    assign shift_carry_out = cout_q;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
module tb_val2_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, immd, is_mem_command, carry_in;
    logic [31:0] Rm;
    logic [11:0] shift_operand;
    logic        busy, done, shift_carry_out;
    logic [31:0] val2_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    val2_shift_sequencer #(.REGISTER_LEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .Rm(Rm), .shift_operand(shift_operand),
        .immd(immd), .is_mem_command(is_mem_command), .carry_in(carry_in),
        .busy(busy), .done(done), .val2_out(val2_out), .shift_carry_out(shift_carry_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: result, carry and shift count straight from the operand-2 rules.
    function automatic void model(input logic [31:0] rm, input logic [11:0] so, input logic im,
                                  input logic mem, input logic ci,
                                  output logic [31:0] v, output logic c, output int n);
        logic [63:0]        t64;
        logic signed [63:0] s64;
        logic [31:0]        v8;
        int                 amt, r;
        v = rm; c = ci; n = 0;
        amt = int'(so[11:7]);
        if (mem) begin
            v = {20'b0, so};
        end else if (im) begin
            r  = 2 * int'(so[11:8]);
            v8 = {24'b0, so[7:0]};
            v  = v8;
            n  = r;
            if (r != 0) begin
                v = (v8 >> r) | (v8 << (32 - r));
                c = v[31];
            end
        end else if (!so[4]) begin
            case (so[6:5])
                2'b00: if (amt != 0) begin
                    t64 = {32'b0, rm} << amt; v = t64[31:0]; c = t64[32]; n = amt;
                end
                2'b01: begin
                    if (amt == 0) amt = 32;
                    t64 = {rm, 32'b0} >> amt; v = t64[63:32]; c = t64[31]; n = amt;
                end
                2'b10: begin
                    if (amt == 0) amt = 32;
                    s64 = {rm, 32'b0}; s64 = s64 >>> amt; v = s64[63:32]; c = s64[31]; n = amt;
                end
                default: if (amt != 0) begin
                    v = (rm >> amt) | (rm << (32 - amt)); c = v[31]; n = amt;
                end else begin
`ifdef RRX_EN
                    v = {ci, rm[31:1]}; c = rm[0]; n = 1;
`endif
                end
            endcase
        end
    endfunction

    // Cycle-accurate expectation: one op in flight from start cycle s to done cycle d.
    bit          pend = 0;
    int          s_cyc, d_cyc;
    logic [31:0] p_v, hold_v = 0;
    logic        p_c, hold_c = 0;

    always @(negedge clk) begin : compare
        logic [31:0] mv;
        logic        mc;
        int          mn;
        bit          inshift, exp_done, acc;
        if (chk_en) begin
            inshift  = pend && cyc > s_cyc && cyc < d_cyc;
            exp_done = pend && cyc == d_cyc;
            if (exp_done) begin hold_v = p_v; hold_c = p_c; pend = 0; end
            model(Rm, shift_operand, immd, is_mem_command, carry_in, mv, mc, mn);
            acc = rst && start && !inshift;
            chk("done", {31'b0, done}, {31'b0, exp_done});
            chk("busy", {31'b0, busy}, {31'b0, inshift || (acc && mn > 0)});
            chk("val2_out", val2_out, hold_v);
            chk("carry_out", {31'b0, shift_carry_out}, {31'b0, hold_c});
            if (!rst) begin
                pend = 0; hold_v = 0; hold_c = 0;
            end else if (acc) begin
                pend = 1; s_cyc = cyc; d_cyc = cyc + mn + 1; p_v = mv; p_c = mc;
            end
        end
    end

    task automatic directed(input string name, input logic [31:0] rm, input logic [11:0] so,
                            input logic im, input logic mem, input logic ci,
                            input logic [31:0] ev, input logic ec, input int elat,
                            input bit mid_start);
        logic [31:0] mv;
        logic        mc;
        int          mn, k;
        bit          seen;
        model(rm, so, im, mem, ci, mv, mc, mn);
        chk({name, "_model_val"}, mv, ev);
        chk({name, "_model_carry"}, {31'b0, mc}, {31'b0, ec});
        chk({name, "_model_lat"}, mn + 1, elat);
        @(posedge clk); #1;
        Rm = rm; shift_operand = so; immd = im; is_mem_command = mem; carry_in = ci; start = 1;
        seen = 0;
        for (k = 1; k <= 60 && !seen; k++) begin
            @(posedge clk); #1;
            start = (mid_start && k == 10);
            if (mid_start && k == 10) begin
                Rm = 32'hFFFF_FFFF; shift_operand = 12'h000; is_mem_command = 1;
            end
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
        else begin
            chk({name, "_lat"}, k - 1, elat);
            chk({name, "_val"}, val2_out, ev);
            chk({name, "_carry"}, {31'b0, shift_carry_out}, {31'b0, ec});
        end
        is_mem_command = 0;
    endtask

    initial begin
        bit saw_done;
        rst = 0; start = 0; immd = 0; is_mem_command = 0; carry_in = 0;
        Rm = 0; shift_operand = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_val", val2_out, 0);
        chk("rst_carry", {31'b0, shift_carry_out}, 0);
        @(posedge clk); #1 rst = 1;

        directed("mem_abc",  32'h1234_5678, 12'hABC, 0, 1, 1, 32'h0000_0ABC, 1, 1,  0);
        directed("imm_4ff",  32'h1234_5678, 12'h4FF, 1, 0, 0, 32'hFF00_0000, 1, 9,  0);
        directed("lsr0",     32'h8000_0001, 12'h020, 0, 0, 0, 32'h0000_0000, 1, 33, 1);
        directed("asr4",     32'h8000_0000, 12'h240, 0, 0, 1, 32'hF800_0000, 0, 5,  0);
        directed("lsl31",    32'h0000_0003, 12'hF80, 0, 0, 0, 32'h8000_0000, 1, 32, 0);
        directed("regshift", 32'hCAFE_0001, 12'h010, 0, 0, 1, 32'hCAFE_0001, 1, 1,  0);
`ifdef RRX_EN
        directed("ror0",     32'h0000_0003, 12'h060, 0, 0, 1, 32'h8000_0001, 1, 2,  0);
`else
        directed("ror0",     32'h0000_0003, 12'h060, 0, 0, 1, 32'h0000_0003, 1, 1,  0);
`endif

        // Reset in the middle of a shift.
        @(posedge clk); #1;
        Rm = 0; shift_operand = 12'h4FF; immd = 1; start = 1;
        @(posedge clk); #1 start = 0; immd = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_val", val2_out, 0);
        chk("midrst_carry", {31'b0, shift_carry_out}, 0);
        saw_done = 0;
        repeat (12) begin @(negedge clk); if (done) saw_done = 1; end
        chk("midrst_no_done", {31'b0, saw_done}, 0);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst            = ($urandom_range(0, 59) != 0);
            start          = ($urandom_range(0, 2) == 0);
            Rm             = ($urandom_range(0, 4) == 0) ? 32'h8000_0001 : $urandom;
            shift_operand  = 12'($urandom);
            if ($urandom_range(0, 3) == 0) shift_operand[11:7] = 5'd0;
            immd           = ($urandom_range(0, 3) == 0);
            is_mem_command = ($urandom_range(0, 5) == 0);
            carry_in       = 1'($urandom);
        end
        @(posedge clk); #1 start = 0; rst = 1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/val2_shift_sequencer.md
VAL2_SHIFT_SEQUENCER -- requirements
Module: val2_shift_sequencer

Interface
REQ-001 SHALL have parameter REGISTER_LEN, default 32, the operand/result width.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  a one-cycle request to begin an operand-2 computation.
REQ-005 SHALL have port Rm  input  REGISTER_LEN  the source register value.
REQ-006 SHALL have port shift_operand  input  12  the instruction bits [11:0].
REQ-007 SHALL have port immd  input  1  the immediate-operand flag.
REQ-008 SHALL have port is_mem_command  input  1  set for a load/store, giving an offset form.
REQ-009 SHALL have port carry_in  input  1  the current C flag.
REQ-010 SHALL have port busy  output  1  high while a computation is in progress.
REQ-011 SHALL have port done  output  1  a one-cycle pulse when the result is valid.
REQ-012 SHALL have port val2_out  output  REGISTER_LEN  the registered result, held until the next result.
REQ-013 SHALL have port shift_carry_out  output  1  the shifter carry, valid with done.

Function
REQ-014 SHALL use an FSM with states IDLE, SHIFT and DONE.
REQ-015 SHALL accept start only in IDLE or DONE, and SHALL ignore start in SHIFT.
REQ-016 SHALL, on accepting start, capture all inputs into a working register, a 6-bit count N, a shift type and a carry.
REQ-017 SHALL, when is_mem_command=1, load the working register with {zeros, shift_operand} and set N=0; immd is ignored.
REQ-018 SHALL, when immd=1, load {zeros, shift_operand[7:0]}, set N=2*shift_operand[11:8], and use type ROR.
REQ-019 SHALL, when immd=0 and shift_operand[4]=0, load Rm, set the type from shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR) and set N=shift_operand[11:7].
REQ-020 SHALL treat an LSR or ASR amount of 0 as N=32.
REQ-021 SHALL, when immd=0 and shift_operand[4]=1 (register-specified shift, not supported), load Rm with N=0.
REQ-022 SHALL go from start to DONE directly when N=0, or otherwise to SHIFT.
REQ-023 SHALL, in SHIFT, shift the working register by one bit per cycle, record the bit shifted out as carry, and decrement N.
REQ-024 SHALL leave SHIFT for DONE on the cycle the remaining count reaches 0, so done follows start by N+1 cycles.
REQ-025 SHALL update val2_out and shift_carry_out on the cycle done is asserted.
REQ-026 SHALL assert done for exactly one cycle in DONE.
REQ-027 SHALL return from DONE to IDLE, or to SHIFT/DONE if a new start is present in that cycle.
REQ-028 SHALL set busy = (state==SHIFT) | (start accepted with N>0); busy is the pipeline stall.
REQ-029 SHALL set shift_carry_out = carry_in for N=0 with no RRX.
REQ-030 SHALL set shift_carry_out = the final result[31] for an immediate rotate with N>0.
REQ-031 SHALL, for LSL, LSR and ASR, set shift_carry_out to the last bit shifted out.

Reset
REQ-032 SHALL, when rst=0 at a clock edge, go to IDLE with busy=0, done=0, val2_out=0, shift_carry_out=0 and the count at 0.
REQ-033 SHALL, on reset mid-SHIFT, abandon the computation with no done pulse.
REQ-034 SHALL give reset priority over start.

Configuration
REQ-035 SHALL, when RRX_EN is defined, treat a register ROR with amount 0 as RRX.
REQ-036 SHALL, for RRX, take one SHIFT cycle with result {carry_in, Rm[31:1]}, shift_carry_out=Rm[0] and done 2 cycles after start.
REQ-037 SHALL, when RRX_EN is undefined, treat a register ROR with amount 0 as N=0: result Rm, carry=carry_in, done 1 cycle after start.

Verification
REQ-038 SHALL cover: is_mem_command=1, shift_operand=12'hABC -> val2_out=32'h00000ABC, done 1 cycle after start, busy never high.
REQ-039 SHALL cover: immd=1, shift_operand=12'h4FF -> 8 SHIFT cycles, val2_out=32'hFF000000, shift_carry_out=1, done at cycle 9.
REQ-040 SHALL cover: Rm=32'h80000001, LSR with amount 0 -> 32 cycles, val2_out=0, shift_carry_out=1; start pulsed mid-SHIFT is ignored.
REQ-041 SHALL cover: Rm=32'h80000000, ASR #4 -> val2_out=32'hF8000000, carry=0; Rm=32'h00000003, LSL #31 -> 32'h80000000, carry=1.
REQ-042 SHALL cover: rst=0 for one cycle mid-SHIFT -> IDLE next cycle, outputs 0, no done pulse.
REQ-043 SHALL cover: ROR #0, Rm=32'h00000003, carry_in=1 -> with RRX_EN 32'h80000001 and carry 1; without it 32'h00000003 and carry 1.
